// File: rtl/count_sched_pkg.sv
// count_sched shared types: FSM encoding, requester count, default width.
// Imported by the interface, the arbiter and the top.
package count_sched_pkg;

    localparam int NUM_REQ   = 2;
    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/count_sched_if.sv
// count_sched request/status bundle.
// The master side drives requests; the slave side is the scheduler.
interface count_sched_if
    import count_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic [NUM_REQ-1:0] req;
    logic [WIDTH-1:0]   limit0;
    logic [WIDTH-1:0]   limit1;
    logic               abort;
    logic [NUM_REQ-1:0] gnt;
    logic               busy;
    logic [NUM_REQ-1:0] done;
    logic [WIDTH-1:0]   value;

    modport master (
        output req,
        output limit0,
        output limit1,
        output abort,
        input  gnt,
        input  busy,
        input  done,
        input  value
    );

    modport slave (
        input  req,
        input  limit0,
        input  limit1,
        input  abort,
        output gnt,
        output busy,
        output done,
        output value
    );

endinterface

// File: rtl/count_sched_rr_arb2.sv
// Two-way round-robin arbiter for count_sched.
// The pointer flips to the loser of each grant taken.
module rr_arb2
    import count_sched_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               take,
    output logic [NUM_REQ-1:0] win
);

    logic ptr;

    always_comb begin
        win = '0;
        unique case (req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = ptr ? 2'b10 : 2'b01;
            default: win = '0;
        endcase
    end

    // win[0] set means requester 0 won, so prefer 1 next
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= 1'b0;
        end else if (take && (|win)) begin
            ptr <= win[0];
        end
    end

endmodule

// File: rtl/count_sched.sv
// Shared counter scheduler: grants one of two requesters, counts to
// the winner's latched limit, pulses done; all outputs registered.
module count_sched
    import count_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
)
(
    input  logic         clk,
    input  logic         reset,
    count_sched_if.slave bus
);

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   value_q;
    logic [WIDTH-1:0]   value_d;
    logic [WIDTH-1:0]   lim_q;
    logic [WIDTH-1:0]   lim_d;
    logic [NUM_REQ-1:0] own_q;
    logic [NUM_REQ-1:0] own_d;
    logic [NUM_REQ-1:0] gnt_q;
    logic [NUM_REQ-1:0] gnt_d;
    logic [NUM_REQ-1:0] done_q;
    logic [NUM_REQ-1:0] done_d;
    logic               busy_q;
    logic               busy_d;
    logic [NUM_REQ-1:0] win;
    logic               take;

    assign take = (state_q == ST_IDLE);

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (bus.req),
        .take  (take),
        .win   (win)
    );

    always_comb begin
        state_d = state_q;
        value_d = value_q;
        lim_d   = lim_q;
        own_d   = own_q;
        gnt_d   = gnt_q;
        busy_d  = busy_q;
        done_d  = '0;
        unique case (state_q)
            ST_IDLE: begin
                gnt_d   = '0;
                busy_d  = 1'b0;
                value_d = '0;
                if (|win) begin
                    state_d = ST_RUN;
                    own_d   = win;
                    gnt_d   = win;
                    busy_d  = 1'b1;
                    lim_d   = win[1] ? bus.limit1 : bus.limit0;
                end
            end
            ST_RUN: begin
                // abort beats the terminal-count match
                if (bus.abort) begin
                    state_d = ST_IDLE;
                    value_d = '0;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                end else if (value_q == lim_q) begin
                    state_d = ST_DONE;
                    gnt_d   = '0;
                    done_d  = own_q;
                end else begin
                    value_d = value_q + WIDTH'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                value_d = '0;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                value_d = '0;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            value_q <= '0;
            lim_q   <= '0;
            own_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            lim_q   <= lim_d;
            own_q   <= own_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.value = value_q;

endmodule

// File: tb/tb_count_sched.sv
// Self-checking bench for count_sched: directed scenarios plus
// randomized jobs against a job-level reference model.
module tb_count_sched;
    import count_sched_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    logic pref = 1'b0;

    always #5 clk = ~clk;

    count_sched_if #(.WIDTH(W)) bus ();

    count_sched #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One job from an IDLE cycle: grant, limit+1 RUN cycles, DONE, IDLE.
    // The model knows only the rules: single requester wins, else the
    // preferred one wins and preference moves to the other requester.
    task automatic run_job(input logic [1:0] rq, input logic [7:0] l0,
                           input logic [7:0] l1, input int ab_at,
                           input bit noise);
        logic       w;
        logic [1:0] oh;
        logic [7:0] lim;
        logic [12:0] obs;
        logic [12:0] exp;
        w = (rq == 2'b01) ? 1'b0 : (rq == 2'b10) ? 1'b1 : pref;
        pref = ~w;
        oh = w ? 2'b10 : 2'b01;
        lim = w ? l1 : l0;
        bus.req = rq;
        bus.limit0 = l0;
        bus.limit1 = l1;
        bus.abort = noise ? 1'($urandom) : 1'b0;
        tick;
        bus.abort = 1'b0;
        for (int k = 0; k <= int'(lim); k++) begin
            obs = {bus.gnt, bus.busy, bus.done, bus.value};
            exp = {oh, 1'b1, 2'b00, 8'(k)};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL run k=%0d got=%h want=%h", k, obs, exp);
            end
            if (noise) begin
                bus.req = 2'($urandom);
                bus.limit0 = 8'($urandom);
                bus.limit1 = 8'($urandom);
            end
            if (k == ab_at) begin
                bus.abort = 1'b1;
                tick;
                bus.abort = 1'b0;
                obs = {bus.gnt, bus.busy, bus.done, bus.value};
                total++;
                if (obs !== 13'h0) begin
                    bad++;
                    $display("FAIL abort_idle got=%h want=0", obs);
                end
                bus.req = 2'b00;
                return;
            end
            tick;
        end
        obs = {bus.gnt, bus.busy, bus.done, bus.value};
        exp = {2'b00, 1'b1, oh, lim};
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL done_cycle got=%h want=%h", obs, exp);
        end
        if (noise) bus.abort = 1'($urandom);
        tick;
        bus.abort = 1'b0;
        obs = {bus.gnt, bus.busy, bus.done, bus.value};
        total++;
        if (obs !== 13'h0) begin
            bad++;
            $display("FAIL post_idle got=%h want=0", obs);
        end
        bus.req = 2'b00;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        bus.req = 2'b00;
        bus.abort = 1'b0;
        pref = 1'b0;
        tick;
        tick;
        #2 rst_n = 1'b1;
        tick;
    endtask

    task automatic test_reset;
        logic [12:0] obs;
        rst_n = 1'b0;
        bus.req = 2'b11;
        bus.limit0 = 8'd0;
        bus.limit1 = 8'd9;
        bus.abort = 1'b0;
        pref = 1'b0;
        tick;
        tick;
        tick;
        obs = {bus.gnt, bus.busy, bus.done, bus.value};
        total++;
        if (obs !== 13'h0) begin
            bad++;
            $display("FAIL reset_state got=%h want=0", obs);
        end
        #3 rst_n = 1'b1;
        #1;
        total++;
        if (bus.gnt !== 2'b00) begin
            bad++;
            $display("FAIL early_grant got=%b want=00", bus.gnt);
        end
        @(posedge clk);
        #1;
        pref = 1'b1;
        obs = {bus.gnt, bus.busy, bus.done, bus.value};
        total++;
        if (obs !== {2'b01, 1'b1, 2'b00, 8'd0}) begin
            bad++;
            $display("FAIL first_grant got=%h want=%h", obs,
                     {2'b01, 1'b1, 2'b00, 8'd0});
        end
        tick;
        obs = {bus.gnt, bus.busy, bus.done, bus.value};
        total++;
        if (obs !== {2'b00, 1'b1, 2'b01, 8'd0}) begin
            bad++;
            $display("FAIL first_done got=%h want=%h", obs,
                     {2'b00, 1'b1, 2'b01, 8'd0});
        end
        tick;
        obs = {bus.gnt, bus.busy, bus.done, bus.value};
        total++;
        if (obs !== 13'h0) begin
            bad++;
            $display("FAIL first_idle got=%h want=0", obs);
        end
        bus.req = 2'b00;
    endtask

    task automatic test_basic;
        run_job(2'b01, 8'd3, 8'd0, -1, 1'b0);
    endtask

    task automatic test_back_to_back;
        do_reset;
        run_job(2'b11, 8'd2, 8'd4, -1, 1'b0);
        run_job(2'b11, 8'd2, 8'd4, -1, 1'b0);
        run_job(2'b11, 8'd2, 8'd4, -1, 1'b0);
    endtask

    task automatic test_zero_limit;
        run_job(2'b10, 8'd7, 8'd0, -1, 1'b0);
    endtask

    task automatic test_max_limit;
        run_job(2'b01, 8'd255, 8'd9, -1, 1'b0);
    endtask

    task automatic test_abort;
        run_job(2'b11, 8'd10, 8'd10, 5, 1'b0);
        run_job(2'b11, 8'd3, 8'd3, -1, 1'b0);
        run_job(2'b10, 8'd0, 8'd4, 4, 1'b0);
        run_job(2'b11, 8'd1, 8'd2, -1, 1'b0);
    endtask

    task automatic test_reset_mid_run;
        logic [12:0] obs;
        bus.req = 2'b01;
        bus.limit0 = 8'd20;
        tick;
        total++;
        if (bus.gnt !== 2'b01) begin
            bad++;
            $display("FAIL mid_grant got=%b want=01", bus.gnt);
        end
        bus.req = 2'b00;
        tick;
        tick;
        tick;
        #3 rst_n = 1'b0;
        #1;
        obs = {bus.gnt, bus.busy, bus.done, bus.value};
        total++;
        if (obs !== 13'h0) begin
            bad++;
            $display("FAIL async_clear got=%h want=0", obs);
        end
        pref = 1'b0;
        bus.req = 2'b11;
        #2 rst_n = 1'b1;
        bus.req = 2'b00;
        tick;
        obs = {bus.gnt, bus.busy, bus.done, bus.value};
        total++;
        if (obs !== 13'h0) begin
            bad++;
            $display("FAIL post_reset got=%h want=0", obs);
        end
        run_job(2'b11, 8'd2, 8'd5, -1, 1'b0);
    endtask

    task automatic test_random;
        logic [1:0] rq;
        int         ab;
        for (int n = 0; n < 40; n++) begin
            rq = 2'($urandom_range(1, 3));
            ab = ($urandom % 3 == 0) ? int'($urandom_range(0, 15)) : -1;
            run_job(rq, 8'($urandom_range(0, 15)),
                    8'($urandom_range(0, 15)), ab, 1'b1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req = 2'b00;
        bus.limit0 = 8'd0;
        bus.limit1 = 8'd0;
        bus.abort = 1'b0;
        test_reset;
        test_basic;
        test_back_to_back;
        test_zero_limit;
        test_max_limit;
        test_abort;
        test_reset_mid_run;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/count_sched.md
COUNT_SCHED -- requirements
Module: count_sched

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter WIDTH, default 8, SHALL set the counter and limit width.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  asynchronous active-low reset.
REQ-005 req  in  2  per-requester count request, level; bit i belongs to requester i.
REQ-006 limit0  in  WIDTH  terminal count for requester 0, sampled at grant.
REQ-007 limit1  in  WIDTH  terminal count for requester 1, sampled at grant.
REQ-008 abort  in  1  terminates the current job without a done pulse.
REQ-009 gnt  out  2  one-hot owner of the counter, all zero when idle.
REQ-010 busy  out  1  high while a job is in RUN or DONE.
REQ-011 done  out  2  one-cycle completion pulse to the owning requester.
REQ-012 value  out  WIDTH  current count of the shared counter.

Function
REQ-013 The state machine SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 In IDLE, the block SHALL hold gnt=0, busy=0, done=0 and value=0.
REQ-015 In IDLE with any req bit high at a clock edge, the block SHALL select a winner, latch that requester's limit, and enter RUN on that edge.
REQ-016 Winner selection SHALL work as follows:
- Single requester: that requester wins.
- Both requesting: the requester named by a 1-bit round-robin pointer wins.
- After every grant, the pointer SHALL point to the other requester.
REQ-017 On RUN entry, gnt SHALL be one-hot for the winner, busy=1 and value=0 (one-cycle req-to-gnt latency).
REQ-018 In RUN, value SHALL increment by 1 per clock, so the k-th RUN cycle shows value=k-1.
REQ-019 When value equals the latched limit in RUN, the next edge SHALL enter DONE, giving RUN a length of limit+1 cycles.
REQ-020 limit=0 SHALL give exactly one RUN cycle with value=0.
REQ-021 limit=2^WIDTH-1 SHALL count to all-ones and SHALL never wrap to 0 within RUN.
REQ-022 In DONE, for exactly one cycle, the block SHALL drive:
- done one-hot for the owner;
- gnt=0 and busy=1;
- value held at limit.
The block SHALL then return to IDLE.
REQ-023 Changes to limit0/limit1 after grant SHALL NOT affect the running job.
REQ-024 Deasserting req during RUN SHALL NOT stop the job.
REQ-025 req SHALL be ignored in RUN and DONE, and a new grant SHALL need at least one IDLE cycle.
REQ-026 abort sampled high in RUN SHALL move the block to IDLE on that edge with value=0, gnt=0 and no done pulse.
REQ-027 abort SHALL have no effect in IDLE or DONE.
REQ-028 abort on the same edge as the limit match SHALL take priority, so no done pulse is issued.
REQ-029 The round-robin pointer SHALL still have advanced for an aborted job.
REQ-030 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-031 reset low SHALL asynchronously force the following, regardless of state:
- state=IDLE, pointer=0 (requester 0 preferred);
- value=0, gnt=0, done=0, busy=0;
- latched limit=0.
REQ-032 A reset asserted mid-RUN SHALL discard the job with no done pulse.
REQ-033 After reset deasserts, the first grant SHALL occur no earlier than the first rising edge on which reset is high.

Structure
REQ-034 The state encoding (IDLE, RUN, DONE), NUM_REQ=2 and the default WIDTH SHALL live in a shared package count_sched_pkg.
REQ-035 Winner selection and the pointer SHALL be implemented in one sub-module rr_arb2.
REQ-036 The counter, FSM and output registers SHALL reside in count_sched.

Verification
REQ-037 Reset, then req=2'b01 with limit0=3 -> gnt=01 one cycle later; value 0,1,2,3; done=01 for one cycle; back in IDLE with value=0.
REQ-038 req=2'b11 held after reset -> grants in order 01, 10, 01, each job separated by a DONE cycle and an IDLE cycle.
REQ-039 limit1=0 with only req[1] -> exactly one RUN cycle with value=0, then done=10.
REQ-040 limit0=255 -> value reaches 255, no wrap to 0 during RUN, done=01 after 256 RUN cycles.
REQ-041 abort pulsed when value=5 with limit=10 -> IDLE on the next edge, value=0, done never asserted; the next simultaneous request goes to the other requester.
REQ-042 reset driven low mid-RUN between clock edges -> outputs clear immediately without a clock; after release with req=11, the first grant goes to requester 0.
